// File: rtl/fifo_pkg.sv
// Shared FIFO constants and Gray-code helpers used by both clock domains.
package fifo_pkg;

  localparam int unsigned DefaultDsize = 8;
  localparam int unsigned DefaultAsize = 4;

  // Helpers work on 32 bits; callers cast to the pointer width (ASIZE+1 <= 32).
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_domain_if.sv
// Read-side bundle: consumer handshake, array read port and cross-domain pointers.
interface fifo_rd_domain_if
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DefaultDsize,
  parameter int unsigned ASIZE = DefaultAsize
);

  logic             rinc;
  logic [ASIZE:0]   wptr;
  logic [DSIZE-1:0] mem_q;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
  logic             rempty;
  logic [DSIZE-1:0] rdata;

  // Environment side: consumer, write domain and storage array.
  modport master (
    output rinc, wptr, mem_q,
    input  raddr, rptr, rempty, rdata
  );

  // Read-domain logic side.
  modport slave (
    input  rinc, wptr, mem_q,
    output raddr, rptr, rempty, rdata
  );

endinterface

// File: rtl/ptr_sync2.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock.
module ptr_sync2 #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q1_q;
  logic [Width-1:0] q2_q;

  // Plain flop chain; no logic between stages so each bit resolves independently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/fifo_rd_domain.sv
// Read-clock half of the async FIFO: wptr sync, read pointers, empty flag, read data.
module fifo_rd_domain
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DefaultDsize,
  parameter int unsigned ASIZE = DefaultAsize
) (
  input  logic           rclk,
  input  logic           rrst_n,
  fifo_rd_domain_if.slave bus
);

  logic [ASIZE:0]   rq2_wptr;
  logic [ASIZE:0]   rbin_q;
  logic [ASIZE:0]   rbin_d;
  logic [ASIZE:0]   rgray_d;
  logic [ASIZE:0]   rptr_q;
  logic             rempty_q;
  logic [DSIZE-1:0] rdata_q;
  logic             rd_en;

  ptr_sync2 #(
    .Width (ASIZE + 1)
  ) u_wptr_sync (
    .clk_i  (rclk),
    .rst_ni (rrst_n),
    .d_i    (bus.wptr),
    .q_o    (rq2_wptr)
  );

  // Next read pointer; a request while empty is dropped here.
  always_comb begin
    rd_en   = bus.rinc & ~rempty_q;
    rbin_d  = rbin_q + (ASIZE + 1)'(rd_en);
    rgray_d = (ASIZE + 1)'(bin2gray(32'(rbin_d)));
  end

  // Pointer and empty registers; empty uses the next pointer so the last read sets it.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      rempty_q <= (rgray_d == rq2_wptr);
    end
  end

  // Capture the word at the pre-increment address on an accepted read.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= bus.mem_q;
    end
  end

  assign bus.raddr  = rbin_q[ASIZE-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.rempty = rempty_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_fifo_rd_domain.sv
// Directed bench for fifo_rd_domain with a small write-side and array model.
module tb_fifo_rd_domain;
  import fifo_pkg::*;

  logic rclk;
  logic rrst_n;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mem [16];
  logic [4:0] wbin;
  logic [4:0] prev_rptr;
  logic [7:0] q [$];
  int         wr_cnt;
  int         rd_cnt;

  fifo_rd_domain_if #(.DSIZE(8), .ASIZE(4)) bus ();

  fifo_rd_domain #(
    .DSIZE (8),
    .ASIZE (4)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  assign bus.mem_q = mem[bus.raddr];

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [4:0] g5(input logic [4:0] b);
    return 5'(bin2gray(32'(b)));
  endfunction

  function automatic logic [7:0] wdat(input int pass, input int k);
    return 8'(8'h40 + pass * 8'h20 + k * 3);
  endfunction

  // One write per call at most, so wptr moves one Gray step at a time.
  task automatic push_word(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    q.push_back(d);
    wbin = wbin + 5'd1;
    bus.wptr = g5(wbin);
    wr_cnt++;
  endtask

  // Detect accepted reads from rptr movement and score them.
  task automatic observe();
    logic [4:0] cur;
    logic [7:0] exp_d;
    cur = bus.rptr;
    chk("gray_step", 32'($countones(cur ^ prev_rptr) <= 1), 32'd1);
    if (cur != prev_rptr) begin
      rd_cnt++;
      chk("no_underflow", 32'(rd_cnt <= wr_cnt), 32'd1);
      if (q.size() > 0) begin
        exp_d = q.pop_front();
        chk("rand_rdata", 32'(bus.rdata), 32'(exp_d));
      end
    end
    if (!bus.rempty) chk("empty_safe", 32'(wr_cnt > rd_cnt), 32'd1);
    prev_rptr = cur;
  endtask

  initial begin
    rrst_n   = 1'b0;
    bus.rinc = 1'b0;
    bus.wptr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    #12;
    chk("rst_rempty", 32'(bus.rempty), 32'd1);
    chk("rst_rptr", 32'(bus.rptr), 32'd0);
    chk("rst_raddr", 32'(bus.raddr), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    tick();
    rrst_n = 1'b1;

    // Fill latency: empty drops on the 3rd edge after wptr moves
    bus.wptr = 5'b00001;
    tick();
    chk("fill_e1", 32'(bus.rempty), 32'd1);
    tick();
    chk("fill_e2", 32'(bus.rempty), 32'd1);
    tick();
    chk("fill_e3", 32'(bus.rempty), 32'd0);

    // Drain three words
    mem[0] = 8'hA0;
    mem[1] = 8'hA1;
    mem[2] = 8'hA2;
    bus.wptr = 5'b00010;
    tick();
    tick();
    tick();
    chk("drain_pre_empty", 32'(bus.rempty), 32'd0);
    bus.rinc = 1'b1;
    tick();
    chk("drain0_rdata", 32'(bus.rdata), 32'hA0);
    chk("drain0_rptr", 32'(bus.rptr), 32'b00001);
    chk("drain0_empty", 32'(bus.rempty), 32'd0);
    tick();
    chk("drain1_rdata", 32'(bus.rdata), 32'hA1);
    chk("drain1_rptr", 32'(bus.rptr), 32'b00011);
    chk("drain1_empty", 32'(bus.rempty), 32'd0);
    tick();
    chk("drain2_rdata", 32'(bus.rdata), 32'hA2);
    chk("drain2_rptr", 32'(bus.rptr), 32'b00010);
    chk("drain2_empty", 32'(bus.rempty), 32'd1);

    // Reads while empty are ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_rd_rptr", 32'(bus.rptr), 32'b00010);
      chk("empty_rd_rdata", 32'(bus.rdata), 32'hA2);
      chk("empty_rd_raddr", 32'(bus.raddr), 32'd3);
    end

    // Mid-cycle reset takes effect without a clock edge
    #3;
    rrst_n = 1'b0;
    bus.wptr = '0;
    #1;
    chk("midrst_rempty", 32'(bus.rempty), 32'd1);
    chk("midrst_rptr", 32'(bus.rptr), 32'd0);
    chk("midrst_raddr", 32'(bus.raddr), 32'd0);
    chk("midrst_rdata", 32'(bus.rdata), 32'd0);
    tick();
    tick();
    chk("rst_hold_rptr", 32'(bus.rptr), 32'd0);
    chk("rst_hold_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_hold_empty", 32'(bus.rempty), 32'd1);
    bus.rinc = 1'b0;
    rrst_n = 1'b1;
    wbin = '0;
    wr_cnt = 0;
    rd_cnt = 0;

    // Wrap-around: 16 writes then 16 reads, twice
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 16; k++) begin
        push_word(wdat(pass, k));
        tick();
      end
      tick();
      tick();
      tick();
      chk("wrap_full_nonempty", 32'(bus.rempty), 32'd0);
      bus.rinc = 1'b1;
      for (int k = 1; k <= 16; k++) begin
        tick();
        chk("wrap_rdata", 32'(bus.rdata), 32'(wdat(pass, k - 1)));
        chk("wrap_rptr", 32'(bus.rptr), 32'(g5(5'(pass * 16 + k))));
        chk("wrap_raddr", 32'(bus.raddr), 32'(k % 16));
        chk("wrap_rempty", 32'(bus.rempty), 32'(k == 16));
      end
      if (pass == 0) chk("wrap_msb", 32'(bus.rptr), 32'b11000);
      bus.rinc = 1'b0;
      q.delete();
    end
    rd_cnt = wr_cnt;

    // Random reads with legal one-step writes
    prev_rptr = bus.rptr;
    for (int i = 0; i < 400; i++) begin
      tick();
      observe();
      bus.rinc = 1'($urandom_range(0, 1));
      if ((wr_cnt - rd_cnt) < 16 && $urandom_range(0, 2) != 0) begin
        push_word(8'($urandom));
      end
    end

    // Drain whatever is left, bounded
    bus.rinc = 1'b1;
    for (int i = 0; i < 40 && (q.size() > 0 || rd_cnt < wr_cnt); i++) begin
      tick();
      observe();
    end
    tick();
    tick();
    tick();
    observe();
    chk("final_empty", 32'(bus.rempty), 32'd1);
    chk("final_drained", 32'(q.size()), 32'd0);
    chk("final_count", 32'(rd_cnt), 32'(wr_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
